// File: rtl/feinv.sv
// feinv: field inverter for GF(2^255-19), out = a_in^EXP mod p.
// MSB-first square-and-multiply driving an external femul over its
// start/done handshake; exactly one multiplication is outstanding at a time.
//
// Ports:
//   clock, reset_n     rising-edge clock, synchronous active-low reset
//   start, a_in        request and operand (sampled only in IDLE)
//   busy, done, out    status and result (done is a one-cycle pulse, out held)
//   mul_start, mul_a,
//   mul_b              femul request and operands (held through the wait)
//   mul_done, mul_out  femul completion pulse and product
`timescale 1ns/1ps
module feinv #(
  parameter int unsigned      BITS = 255,
  parameter logic [BITS-1:0]  EXP  = {{(BITS-5){1'b1}}, 5'b01011}
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [BITS-1:0] a_in,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] out,
  output logic            mul_start,
  output logic [BITS-1:0] mul_a,
  output logic [BITS-1:0] mul_b,
  input  logic            mul_done,
  input  logic [BITS-1:0] mul_out
);

  localparam int unsigned IDX_W = $clog2(BITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SQ_ISSUE = 3'd1,
    SQ_WAIT  = 3'd2,
    MU_ISSUE = 3'd3,
    MU_WAIT  = 3'd4,
    FINISH   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [BITS-1:0]   acc_q, acc_d;
  logic [BITS-1:0]   base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mul_start_q, mul_start_d;
  logic [BITS-1:0]   out_q, out_d;
  logic [BITS-1:0]   mul_a_q, mul_a_d;
  logic [BITS-1:0]   mul_b_q, mul_b_d;

  logic accept;
  logic take;
  logic exp_bit;
  logic last_bit;

  assign accept   = (state_q == IDLE) && start;
  // mul_done is only meaningful while waiting; stale completions are dropped
  assign take     = mul_done && ((state_q == SQ_WAIT) || (state_q == MU_WAIT));
  assign exp_bit  = EXP[idx_q];
  assign last_bit = (idx_q == '0);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      out_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mul_start_q <= mul_start_d;
      out_q       <= out_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = SQ_ISSUE;
      SQ_ISSUE: state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (mul_done) begin
          if (exp_bit)       state_d = MU_ISSUE;
          else if (last_bit) state_d = FINISH;
          else               state_d = SQ_ISSUE;
        end
      end
      MU_ISSUE: state_d = MU_WAIT;
      MU_WAIT: begin
        if (mul_done) state_d = last_bit ? FINISH : SQ_ISSUE;
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Register inputs; outputs are set on entry to the state that presents them
  always_comb begin
    acc_d       = acc_q;
    base_d      = base_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mul_start_d = 1'b0;
    out_d       = out_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;

    if (accept) begin
      base_d = a_in;
      acc_d  = a_in;
      idx_d  = IDX_W'(BITS - 2);
      busy_d = 1'b1;
    end

    // The bit index advances only when moving on to the next squaring
    if (take) begin
      acc_d = mul_out;
      if (state_d == SQ_ISSUE) idx_d = idx_q - IDX_W'(1);
    end

    if ((state_d == SQ_ISSUE) || (state_d == MU_ISSUE)) begin
      mul_start_d = 1'b1;
      mul_a_d     = acc_d;
      mul_b_d     = (state_d == SQ_ISSUE) ? acc_d : base_d;
    end

    if (state_d == FINISH) begin
      out_d  = acc_d;
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_feinv.sv
// Bench for feinv: behavioural femul with per-operation random latency,
// scoreboard of expected inverses popped on each done pulse.
`timescale 1ns/1ps
module tb_feinv;

  localparam int unsigned BITS = 255;
  localparam int unsigned NW   = BITS + 8;
  localparam logic [BITS-1:0] P    = {{250{1'b1}}, 5'b01101};   // 2^255-19
  localparam logic [BITS-1:0] PM1  = {{250{1'b1}}, 5'b01100};   // p-1
  localparam logic [BITS-1:0] INV2 = {1'b0, {249{1'b1}}, 5'b10111}; // 2^254-9
  localparam int unsigned N_OPS = 506;
  localparam int unsigned N_SQ  = 254;

  typedef struct {
    logic [BITS-1:0] a;
    int unsigned     lmin;
    int unsigned     lmax;
    logic [BITS-1:0] exp_out;
    bit              chk_sq;
    bit              chk_gap;
  } rec_t;

  logic            clock;
  logic            reset_n;
  logic            start;
  logic [BITS-1:0] a_in;
  logic            busy;
  logic            done;
  logic [BITS-1:0] out;
  logic            mul_start;
  logic [BITS-1:0] mul_a;
  logic [BITS-1:0] mul_b;
  logic            mul_done;
  logic [BITS-1:0] mul_out;

  feinv dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .a_in      (a_in),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_out   (mul_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  rec_t sb[$];

  int unsigned     l_min = 1;
  int unsigned     l_max = 1;
  int unsigned     cnt = 0;
  int unsigned     ops = 0;
  int unsigned     sq = 0;
  int unsigned     lsum = 0;
  int unsigned     run_start = 0;
  int unsigned     last_done = 0;
  logic            ovl = 1'b0;
  logic            busy_prev = 1'b0;
  logic [BITS-1:0] pend = '0;

  task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BITS-1:0] mulmod(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
    logic [2*BITS-1:0] pr;
    pr = {{BITS{1'b0}}, x} * {{BITS{1'b0}}, y};
    return BITS'(pr % {{BITS{1'b0}}, P});
  endfunction

  // Inverse of a small k: the unique (m*p+1)/k with m < k that divides exactly
  function automatic logic [BITS-1:0] inv_small(input int unsigned k);
    logic [NW-1:0] num;
    if (k == 0) return '0;
    for (int unsigned m = 0; m < k; m++) begin
      num = NW'(m) * {8'b0, P} + NW'(1);
      if ((num % NW'(k)) == '0) return BITS'(num / NW'(k));
    end
    return '0;
  endfunction

  function automatic rec_t mk(input logic [BITS-1:0] a, input int unsigned lmin,
                              input int unsigned lmax, input logic [BITS-1:0] e,
                              input bit s, input bit g);
    rec_t r;
    r.a = a; r.lmin = lmin; r.lmax = lmax; r.exp_out = e; r.chk_sq = s; r.chk_gap = g;
    return r;
  endfunction

  // femul model plus output monitor, evaluated mid-cycle
  initial begin
    rec_t        r;
    int unsigned lat;
    mul_done = 1'b0;
    mul_out  = '0;
    forever begin
      @(negedge clock);
      mul_done = 1'b0;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done = 1'b1;
          mul_out  = pend;
        end
      end
      if (busy && !busy_prev) begin
        run_start = cyc - 1;
        ops = 0; sq = 0; lsum = 0; ovl = 1'b0;
        if (sb.size() != 0 && sb[0].chk_gap) chk_int("b2b_accept_cycle", run_start, last_done + 1);
      end
      if (mul_start) begin
        if (cnt != 0 || !busy) ovl = 1'b1;
        lat  = $urandom_range(l_max, l_min);
        cnt  = lat;
        pend = mulmod(mul_a, mul_b);
        ops++;
        if (mul_a == mul_b) sq++;
        lsum += lat + 1;
      end
      if (done) begin
        last_done = cyc;
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          r = sb.pop_front();
          chk("result", BITS'(out % P), r.exp_out);
          chk_int("op_count", ops, N_OPS);
          chk_int("overlap", 32'(ovl), 0);
          chk_int("done_latency", cyc - run_start, lsum + 1);
          if (r.lmin == r.lmax)
            chk_int("done_cycle_formula", cyc - run_start, N_OPS * (r.lmin + 1) + 1);
          if (r.chk_sq) chk_int("square_count", sq, N_SQ);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic issue(input rec_t r, input bit push);
    @(negedge clock);
    l_min = r.lmin; l_max = r.lmax;
    a_in  = r.a;
    start = 1'b1;
    if (push) sb.push_back(r);
    @(negedge clock);
    start = 1'b0;
    a_in  = '0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while ((sb.size() != 0 || busy) && n < 30000) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t vec[5];
    int unsigned n;
    bit bad;

    reset_n = 1'b0;
    start   = 1'b1;
    a_in    = BITS'(42);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_int("rst_busy", 32'(busy), 0);
    chk_int("rst_done", 32'(done), 0);
    chk_int("rst_mul_start", 32'(mul_start), 0);
    chk("rst_out", out, '0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    start   = 1'b0;
    a_in    = '0;
    reset_n = 1'b1;

    vec[0] = mk(BITS'(2), 3, 3, INV2, 1'b1, 1'b0);
    vec[1] = mk(BITS'(1), 1, 2, BITS'(1), 1'b0, 1'b0);
    vec[2] = mk('0, 1, 2, '0, 1'b0, 1'b0);
    vec[3] = mk(PM1, 1, 2, PM1, 1'b0, 1'b0);
    vec[4] = mk(BITS'(3), 1, 40, inv_small(3), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      issue(vec[i], 1'b1);
      wait_drain("vector");
    end

    // Repeated start pulses during a run must not disturb it
    issue(mk(BITS'(7), 1, 4, inv_small(7), 1'b0, 1'b0), 1'b1);
    for (int k = 0; k < 20; k++) begin
      repeat (7) @(negedge clock);
      a_in = BITS'(5); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_drain("restart_ignored");

    // Reset in the middle of the 100th operation, stale mul_done follows
    issue(mk(BITS'(4), 3, 6, '0, 1'b0, 1'b0), 1'b0);
    n = 0;
    while (ops < 100 && n < 5000) begin @(negedge clock); n++; end
    chk_int("abort_reached_op100", 32'(ops >= 100), 1);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk_int("abort_busy", 32'(busy), 0);
    chk_int("abort_done", 32'(done), 0);
    chk_int("abort_mul_start", 32'(mul_start), 0);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (busy || done || mul_start) bad = 1'b1;
    end
    chk_int("abort_quiet", 32'(bad), 0);
    issue(mk(BITS'(9), 1, 3, inv_small(9), 1'b0, 1'b0), 1'b1);
    wait_drain("after_abort");

    // start held high across two requests
    @(negedge clock);
    l_min = 1; l_max = 2;
    sb.push_back(mk(BITS'(11), 1, 2, inv_small(11), 1'b0, 1'b0));
    sb.push_back(mk(BITS'(13), 1, 2, inv_small(13), 1'b0, 1'b1));
    a_in = BITS'(11); start = 1'b1;
    n = 0;
    while (!busy && n < 10) begin @(negedge clock); n++; end
    a_in = BITS'(13);
    n = 0;
    while (sb.size() > 1 && n < 30000) begin @(negedge clock); n++; end
    n = 0;
    while (!busy && n < 10) begin @(negedge clock); n++; end
    chk_int("b2b_second_busy", 32'(busy), 1);
    start = 1'b0;
    wait_drain("b2b");

    repeat (50) @(negedge clock);
    chk_int("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
